sine_wb_buffer: RTL
===================

Name: sine_wb_buffer

Overview:
- Writeback buffer directly downstream of the sine unit.
- Captures each {result, out_dest} pair when the sine unit pulses done.
- Queues the pairs in a small FIFO and drains them, in order, to the register-file write port using a valid/ack handshake.
- Tracks operations still in flight in the sine pipeline and drives can_issue, so the dispatcher never issues more sineEna operations than the buffer can absorb. The sine pipeline has no stall input, so this credit is the only backpressure.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- MAX_INFLIGHT, 8, saturation bound of the in-flight counter; must be at least the sine pipeline latency plus DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- sineEna  in  1  issue strobe, the same signal that drives the sine unit; one operation per high cycle.
- done  in  1  sine unit result valid, one cycle per result.
- result  in  32  sine unit IEEE-754 single result.
- out_dest  in  4  sine unit destination register.
- wr_en  out  1  write request to the register file (valid).
- wr_data  out  32  head entry data.
- wr_addr  out  4  head entry destination.
- wr_ack  in  1  register file accepted the write this cycle.
- can_issue  out  1  dispatcher may assert sineEna this cycle.
- count  out  clog2(DEPTH+1)  current FIFO occupancy.
- err  out  1  sticky protocol error flag.

Behaviour:
- Reset (asynchronous, nrst=0):
  - count=0, read/write pointers=0, inflight=0, err=0.
  - wr_en=0, wr_data=0, wr_addr=0, can_issue=1.
  - Storage contents are don't-care.
  - Reset mid-operation discards all queued and in-flight bookkeeping immediately.
- Push:
  - done=1 writes {result, out_dest} at wptr; wptr increments modulo DEPTH and count increments.
- Pop:
  - wr_en && wr_ack advances rptr modulo DEPTH and decrements count.
  - wr_ack while wr_en=0 is ignored.
- Output timing:
  - wr_en = (count != 0), driven from registered state.
  - wr_data and wr_addr show the head entry whenever wr_en=1, and hold 0 when the buffer is empty.
  - No bypass: a result pushed into an empty buffer in cycle N appears on wr_en/wr_data in cycle N+1.
- Handshake rule: while wr_en=1 and wr_ack=0, wr_en, wr_data and wr_addr remain stable.
- Simultaneous push and pop:
  - Both occur and count is unchanged.
  - When full, this is legal and is not an overflow.
  - When count=1, the new entry becomes head on the next cycle.
- Overflow:
  - Condition: done=1, count==DEPTH and no pop in the same cycle.
  - Incoming data is dropped, err is set, and the FIFO state is unchanged.
- In-flight counter:
  - Increments on sineEna and decrements on done; both in the same cycle leave it unchanged.
  - done with inflight==0 sets err and the counter stays at 0.
  - sineEna at MAX_INFLIGHT saturates the counter and sets err.
- Credit:
  - can_issue = (count + inflight) < DEPTH, combinational from registers only.
  - Pops free credit one cycle later.
- err:
  - Sticky once set; cleared only by reset.
  - Has no effect on normal datapath operation.
- Ordering: entries leave in exact arrival order. No reordering by destination, and no merging of writes to the same address.

Test Plan:
- Reset: hold nrst=0 for 2 cycles, then release -> wr_en=0, wr_data=0, count=0, can_issue=1, err=0.
- Single op:
  - Stimulus: sineEna pulse; done some cycles later with result=0x3F3504F3, out_dest=4'h1; wr_ack held 1.
  - Required: can_issue stays 1; wr_en=1 with wr_data=0x3F3504F3, wr_addr=1 exactly one cycle after done; count returns to 0 the cycle after.
- Backpressure:
  - Stimulus: wr_ack=0; five back-to-back sineEna issues.
  - Required: can_issue drops to 0 after the fourth issue.
  - Deliver four done results with dests 1..4 -> count=4, head dest stays 1 and stable across all wait cycles.
  - Raise wr_ack -> writes drain in order 1,2,3,4, one per cycle.
- Full simultaneous:
  - Stimulus: buffer full; done (dest 5, data 0x00000000) and wr_ack in the same cycle.
  - Required: count stays 4, err=0, dest 5 emerges last.
- Overflow: buffer full, wr_ack=0, extra done -> err=1 and stays 1; the four original entries drain intact afterwards.
- Reset mid-drain: assert nrst=0 while count=3 -> wr_en and count clear asynchronously; after release, a new push works from empty.

Source files
------------

// File: rtl/sine_wb_buffer_if.sv
// rtl/sine_wb_buffer_if.sv - issue, result and register-file write bundle for the sine writeback buffer
interface sine_wb_buffer_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          sineEna;
  logic          can_issue;
  logic          done;
  logic [31:0]   result;
  logic [3:0]    out_dest;
  logic          wr_en;
  logic [31:0]   wr_data;
  logic [3:0]    wr_addr;
  logic          wr_ack;
  logic [CW-1:0] count;
  logic          err;

  // The buffer itself
  modport slave (
    input  sineEna, done, result, out_dest, wr_ack,
    output can_issue, wr_en, wr_data, wr_addr, count, err
  );

  // Dispatcher, sine unit and register file seen as one environment
  modport master (
    output sineEna, done, result, out_dest, wr_ack,
    input  can_issue, wr_en, wr_data, wr_addr, count, err
  );
endinterface

// File: rtl/sine_wb_buffer.sv
// rtl/sine_wb_buffer.sv - in-order writeback FIFO with in-flight credit for the sine unit
module sine_wb_buffer #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 8
) (
  input  logic            clk,
  input  logic            nrst,
  sine_wb_buffer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam int SW = ((CW > IW) ? CW : IW) + 1;

  logic [31:0]   data_mem [DEPTH];
  logic [3:0]    dest_mem [DEPTH];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [CW-1:0] count_q;
  logic [IW-1:0] inflight;
  logic          err_q;

  logic pop;
  logic push;
  logic full;
  logic overflow;
  logic inf_full;
  logic inf_empty;
  logic inflight_err;

  // A full buffer may still accept a result when the head leaves in the same cycle
  assign full         = (count_q == CW'(DEPTH));
  assign pop          = (count_q != '0) && bus.wr_ack;
  assign push         = bus.done && (!full || pop);
  assign overflow     = bus.done && full && !pop;
  assign inf_full     = (inflight == IW'(MAX_INFLIGHT));
  assign inf_empty    = (inflight == '0);
  assign inflight_err = (bus.done && inf_empty) ||
                        (bus.sineEna && !bus.done && inf_full);

  // Entry storage; contents are don't-care after reset so no reset term
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wptr] <= bus.result;
      dest_mem[wptr] <= bus.out_dest;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rptr    <= '0;
      wptr    <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Operations issued to the sine pipeline whose results have not yet arrived
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      inflight <= '0;
    end else if (bus.sineEna && !bus.done && !inf_full) begin
      inflight <= inflight + IW'(1);
    end else if (bus.done && !bus.sineEna && !inf_empty) begin
      inflight <= inflight - IW'(1);
    end
  end

  // Sticky protocol error: overflow, unmatched done, or issue past saturation
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      err_q <= 1'b0;
    end else if (overflow || inflight_err) begin
      err_q <= 1'b1;
    end
  end

  assign bus.wr_en     = (count_q != '0);
  assign bus.wr_data   = bus.wr_en ? data_mem[rptr] : 32'h0;
  assign bus.wr_addr   = bus.wr_en ? dest_mem[rptr] : 4'h0;
  assign bus.count     = count_q;
  assign bus.err       = err_q;
  // Every queued entry and every outstanding operation holds one slot of credit
  assign bus.can_issue = (SW'(count_q) + SW'(inflight)) < SW'(DEPTH);
endmodule
